// File: rtl/truth_table_pkg.sv
// Shared types and helpers for the truth-table sweep/capture stage.
package truth_table_pkg;

    localparam int ROW_W   = 3;
    localparam int TABLE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        STORE,
        DONE
    } state_t;

    // True when strictly more than half of the n samples were ones.
    function automatic logic majority(input logic [3:0] ones, input int n);
        return int'(ones) > (n / 2);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer with asynchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/truth_table_capture.sv
// Walks a 3-input logic stage through all rows, majority-samples its output
// and reports the captured 8-bit truth table against an expected code.
module truth_table_capture
    import truth_table_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int NUM_SAMPLES   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [TABLE_W-1:0] expected,
    input  logic               dut_out,
    output logic               in1,
    output logic               in2,
    output logic               in3,
    output logic               busy,
    output logic               done,
    output logic [TABLE_W-1:0] table_out,
    output logic               match,
    output logic [TABLE_W-1:0] mismatch_mask
);

    localparam int ONES_W  = $clog2(NUM_SAMPLES + 1);
    localparam int CNT_MAX = (SETTLE_CYCLES > NUM_SAMPLES) ? SETTLE_CYCLES : NUM_SAMPLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(NUM_SAMPLES - 1);

    state_t             state_q,    state_d;
    logic [ROW_W-1:0]   row_q,      row_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [ONES_W-1:0]  ones_q,     ones_d;
    logic [TABLE_W-1:0] scratch_q,  scratch_d;
    logic [TABLE_W-1:0] expected_q, expected_d;
    logic [TABLE_W-1:0] table_q,    table_d;
    logic               match_q,    match_d;
    logic [TABLE_W-1:0] mask_q,     mask_d;
    logic               dut_sync;
    logic               row_active;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dut_out),
        .q     (dut_sync)
    );

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        cnt_d      = cnt_q;
        ones_d     = ones_q;
        scratch_d  = scratch_q;
        expected_d = expected_q;
        table_d    = table_q;
        match_d    = match_q;
        mask_d     = mask_q;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d    = SETTLE;
                    row_d      = '0;
                    cnt_d      = '0;
                    ones_d     = '0;
                    scratch_d  = '0;
                    expected_d = expected;
                end
            end
            SETTLE: begin
                ones_d = '0;
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SAMPLE: begin
                ones_d = ones_q + ONES_W'(dut_sync);
                if (cnt_q == SAMPLE_LAST) begin
                    cnt_d   = '0;
                    state_d = STORE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STORE: begin
                // Bit 7-r of an 8-bit table is bit ~r of the 3-bit row index.
                scratch_d[~row_q] = majority(4'(ones_q), NUM_SAMPLES);
                if (row_q == ROW_W'(TABLE_W - 1)) begin
                    state_d = DONE;
                    table_d = scratch_d;
                    match_d = (scratch_d == expected_q);
                    mask_d  = scratch_d ^ expected_q;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = SETTLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An abort cancels the sweep and leaves the previous results untouched.
        if (abort && (state_q == SETTLE || state_q == SAMPLE || state_q == STORE)) begin
            state_d = IDLE;
            table_d = table_q;
            match_d = match_q;
            mask_d  = mask_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_q      <= '0;
            cnt_q      <= '0;
            ones_q     <= '0;
            scratch_q  <= '0;
            expected_q <= '0;
            table_q    <= '0;
            match_q    <= 1'b0;
            mask_q     <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            cnt_q      <= cnt_d;
            ones_q     <= ones_d;
            scratch_q  <= scratch_d;
            expected_q <= expected_d;
            table_q    <= table_d;
            match_q    <= match_d;
            mask_q     <= mask_d;
        end
    end

    assign row_active      = (state_q == SETTLE) || (state_q == SAMPLE) || (state_q == STORE);
    assign {in1, in2, in3} = row_active ? row_q : '0;
    assign busy            = (state_q != IDLE);
    assign done            = (state_q == DONE);
    assign table_out       = table_q;
    assign match           = match_q;
    assign mismatch_mask   = mask_q;

endmodule

// File: tb/tb_truth_table_capture.sv
// Randomized scoreboard bench for truth_table_capture with a modelled logic stage.
`timescale 1ns/1ps
module tb_truth_table_capture;

    localparam int R0 = 4 + 3 + 1;
    localparam int R1 = 4 + 1 + 1;

    typedef struct {
        logic [7:0] tbl;
        logic       m;
        logic [7:0] mask;
        int         at;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start0, abort0, start1, abort1;
    logic [7:0] expected0, expected1;
    logic       dut_out0, dut_out1;
    logic       in1_0, in2_0, in3_0, busy0, done0, match0;
    logic       in1_1, in2_1, in3_1, busy1, done1, match1;
    logic [7:0] table0, mask0, table1, mask1;
    logic [2:0] row0, row1;
    logic [7:0] tt0, tt1;
    bit         glitch0, glitch1;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   a0 = 0;
    int   a1 = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream logic-stage models: a truth table, optionally inverting
    // the level present two cycles into each row (lands on the first sample).
    assign row0     = {in1_0, in2_0, in3_0};
    assign row1     = {in1_1, in2_1, in3_1};
    assign dut_out0 = tt0[3'd7 - row0] ^ (glitch0 && (((cyc - a0) % R0) == 2));
    assign dut_out1 = tt1[3'd7 - row1] ^ (glitch1 && (((cyc - a1) % R1) == 2));

    truth_table_capture #(.SETTLE_CYCLES(4), .NUM_SAMPLES(3)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .expected(expected0), .dut_out(dut_out0),
        .in1(in1_0), .in2(in2_0), .in3(in3_0), .busy(busy0), .done(done0),
        .table_out(table0), .match(match0), .mismatch_mask(mask0)
    );

    truth_table_capture #(.SETTLE_CYCLES(4), .NUM_SAMPLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .expected(expected1), .dut_out(dut_out1),
        .in1(in1_1), .in2(in2_1), .in3(in3_1), .busy(busy1), .done(done1),
        .table_out(table1), .match(match1), .mismatch_mask(mask1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        total++;
        if (act !== ex) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h, wanted %h", nm, cyc, act, ex);
        end
    endtask

    // Reference: per row, list the samples the stage delivers, count ones, vote.
    function automatic exp_t model(input logic [7:0] tt, input logic [7:0] ex,
                                   input bit gl, input int ns);
        exp_t e;
        for (int r = 0; r < 8; r++) begin
            int ones = 0;
            for (int k = 0; k < ns; k++) begin
                int v = int'(tt[7 - r]);
                if (gl && k == 0) v = 1 - v;
                ones += v;
            end
            e.tbl[7 - r] = (2 * ones > ns);
        end
        e.m    = (e.tbl == ex);
        e.mask = e.tbl ^ ex;
        e.at   = 0;
        return e;
    endfunction

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Caller is at a negedge with DUT0 idle; returns at the negedge after busy falls.
    task automatic sweep0(input logic [7:0] tt, input logic [7:0] ex, input bit gl, input bit extra);
        exp_t e;
        tt0 = tt; glitch0 = gl; expected0 = ex; start0 = 1'b1;
        a0 = cyc + 1;
        e = model(tt, ex, gl, 3);
        e.at = a0 + 8 * R0;
        q0.push_back(e);
        @(negedge clk);
        start0 = 1'b0;
        expected0 = ~ex;
        chk("busy_after_start", busy0, 1);
        chk("row_first", row0, 0);
        if (extra) begin
            wait_until(a0 + 9);  start0 = 1'b1;
            wait_until(a0 + 10); start0 = 1'b0;
        end
        wait_until(a0 + 3 * R0 + 2);
        chk("row_mid", row0, 3);
        if (extra) begin
            wait_until(a0 + 29); start0 = 1'b1;
            wait_until(a0 + 30); start0 = 1'b0;
        end
        wait_until(a0 + 8 * R0 + 1);
        chk("busy_after_done", busy0, 0);
        chk("row_idle", row0, 0);
        chk("pending0", q0.size(), 0);
    endtask

    task automatic sweep1(input logic [7:0] tt, input logic [7:0] ex, input bit gl);
        exp_t e;
        tt1 = tt; glitch1 = gl; expected1 = ex; start1 = 1'b1;
        a1 = cyc + 1;
        e = model(tt, ex, gl, 1);
        e.at = a1 + 8 * R1;
        q1.push_back(e);
        @(negedge clk);
        start1 = 1'b0;
        wait_until(a1 + 8 * R1 + 1);
        chk("busy1_after_done", busy1, 0);
        chk("pending1", q1.size(), 0);
    endtask

    initial begin : monitor0
        exp_t e;
        forever begin
            @(negedge clk);
            if (done0) begin
                if (q0.size() == 0) begin
                    total++; bad++;
                    $display("FAIL done0_unexpected at cycle %0d: got done=1, wanted done=0", cyc);
                end else begin
                    e = q0.pop_front();
                    $display("dut0 sweep: cycle=%0d table=%h match=%0b mask=%h", cyc, table0, match0, mask0);
                    chk("done0_edge", cyc, e.at);
                    chk("table0", table0, e.tbl);
                    chk("match0", match0, e.m);
                    chk("mask0", mask0, e.mask);
                end
            end
        end
    end

    initial begin : monitor1
        exp_t e;
        forever begin
            @(negedge clk);
            if (done1) begin
                if (q1.size() == 0) begin
                    total++; bad++;
                    $display("FAIL done1_unexpected at cycle %0d: got done=1, wanted done=0", cyc);
                end else begin
                    e = q1.pop_front();
                    $display("dut1 sweep: cycle=%0d table=%h match=%0b mask=%h", cyc, table1, match1, mask1);
                    chk("done1_edge", cyc, e.at);
                    chk("table1", table1, e.tbl);
                    chk("match1", match1, e.m);
                    chk("mask1", mask1, e.mask);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish, wanted finish before 500us");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [7:0] tt;
        logic [7:0] ex;
        start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
        expected0 = 8'h00; expected1 = 8'h00;
        tt0 = 8'h55; tt1 = 8'h55; glitch0 = 1'b0; glitch1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs0", {row0, busy0, done0, table0, match0, mask0}, 0);
        chk("reset_outputs1", {row1, busy1, done1, table1, match1, mask1}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        sweep0(8'h55, 8'h55, 1'b0, 1'b0);   // out = in3
        sweep0(8'h0F, 8'h55, 1'b0, 1'b0);   // out = in1
        sweep0(8'h55, 8'h55, 1'b1, 1'b0);   // one bad sample per row
        sweep0(8'h0F, 8'h0F, 1'b0, 1'b1);   // repeated starts ignored
        sweep0(8'h55, 8'h55, 1'b1, 1'b0);   // back-to-back start

        // Abort mid-sweep keeps previous results.
        @(negedge clk);
        tt0 = 8'hC3; glitch0 = 1'b0; expected0 = 8'hC3; start0 = 1'b1;
        a0 = cyc + 1;
        @(negedge clk);
        start0 = 1'b0;
        wait_until(a0 + 19); abort0 = 1'b1;
        wait_until(a0 + 20); abort0 = 1'b0;
        chk("abort_busy", busy0, 0);
        chk("abort_row", row0, 0);
        chk("abort_table", table0, 8'h55);
        chk("abort_match", match0, 1);
        chk("abort_mask", mask0, 8'h00);
        wait_until(a0 + 90);
        chk("abort_no_done", q0.size(), 0);

        // start and abort together while idle: stays idle.
        start0 = 1'b1; abort0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; abort0 = 1'b0;
        chk("start_abort_idle", busy0, 0);
        repeat (3) @(negedge clk);
        chk("start_abort_idle_later", busy0, 0);

        // Reset mid-sweep clears everything asynchronously.
        tt0 = 8'h3C; start0 = 1'b1;
        a0 = cyc + 1;
        @(negedge clk);
        start0 = 1'b0;
        wait_until(a0 + 30);
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {row0, busy0, done0, table0, match0, mask0}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sweep0(8'h55, 8'h55, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            tt = 8'($urandom);
            ex = ($urandom_range(0, 1) == 1) ? tt : 8'($urandom);
            sweep0(tt, ex, bit'($urandom_range(0, 1)), 1'b0);
        end

        sweep1(8'h55, 8'h55, 1'b1);          // single sample inverted -> AA
        sweep1(8'h55, 8'h55, 1'b0);
        sweep1(8'($urandom), 8'($urandom), 1'b0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
